// File: rtl/cia_eclk_ctrl_if.sv
// Bundles the requester handshake, E-clock phase enables and the CIA port.
// The master side is the requester/clock environment; the slave side is the controller.
interface cia_eclk_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic            clk7_en;
    logic [9:0]      eclk;
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            cia_sel;
    logic            cia_we;
    logic [AW-1:0]   cia_addr;
    logic [DW-1:0]   cia_wdata;
    logic [DW-1:0]   cia_rdata;

    modport master (
        output clk7_en, eclk, req, req_we, req_addr, req_wdata, cia_rdata,
        input  ack, rdata, busy, cia_sel, cia_we, cia_addr, cia_wdata
    );

    modport slave (
        input  clk7_en, eclk, req, req_we, req_addr, req_wdata, cia_rdata,
        output ack, rdata, busy, cia_sel, cia_we, cia_addr, cia_wdata
    );
endinterface

// File: rtl/cia_eclk_ctrl.sv
// Round-robin arbiter and 6800-style cycle sequencer for one CIA port,
// launching at E phase E_START and completing at E phase E_STROBE.
module cia_eclk_ctrl #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned E_START  = 2,
    parameter int unsigned E_STROBE = 9
) (
    input  logic              clk_28,
    input  logic              rst,
    cia_eclk_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_E = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_grant;
    logic            r_last;
    logic [1:0]      r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_busy;
    logic            r_cia_sel;
    logic            r_cia_we;
    logic [AW-1:0]   r_cia_addr;
    logic [DW-1:0]   r_cia_wdata;

    logic            w_eclk_valid;
    logic            w_p_start;
    logic            w_p_strobe;
    logic            w_pick;
    logic [AW-1:0]   w_pick_addr;
    logic [DW-1:0]   w_pick_wdata;

    // A malformed (non one-hot) E phase vector never produces a phase event.
    assign w_eclk_valid = $onehot(bus.eclk);
    assign w_p_start    = bus.clk7_en & bus.eclk[E_START]  & w_eclk_valid;
    assign w_p_strobe   = bus.clk7_en & bus.eclk[E_STROBE] & w_eclk_valid;

    assign w_pick       = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_pick_addr  = w_pick ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
    assign w_pick_wdata = w_pick ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];

    always_ff @(posedge clk_28 or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_last      <= 1'b1;
            r_ack       <= 2'b00;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_cia_sel   <= 1'b0;
            r_cia_we    <= 1'b0;
            r_cia_addr  <= '0;
            r_cia_wdata <= '0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_grant     <= w_pick;
                        r_cia_we    <= bus.req_we[w_pick];
                        r_cia_addr  <= w_pick_addr;
                        r_cia_wdata <= w_pick_wdata;
                        r_busy      <= 1'b1;
                        r_state     <= WAIT_E;
                    end
                end
                WAIT_E: begin
                    if (w_p_start) begin
                        r_cia_sel <= 1'b1;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_p_strobe) begin
                        if (!r_cia_we) begin
                            r_rdata <= bus.cia_rdata;
                        end
                        r_cia_sel <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // The ack lands in the IDLE cycle that follows, two cycles after the strobe phase.
                    r_ack    <= r_grant ? 2'b10 : 2'b01;
                    r_last   <= r_grant;
                    r_cia_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.cia_sel   = r_cia_sel;
    assign bus.cia_we    = r_cia_we;
    assign bus.cia_addr  = r_cia_addr;
    assign bus.cia_wdata = r_cia_wdata;

endmodule

// File: tb/tb_cia_eclk_ctrl.sv
// Directed and randomised checks of the CIA E-clock sequencer against a free-running
// E phase generator (phase n occupies clk_28 ticks 4n..4n+3, enable on the last one).
module tb_cia_eclk_ctrl;

    logic clk_28 = 1'b0;
    logic rst    = 1'b1;
    int   tick   = 0;

    int   checkCount = 0;
    int   errorCount = 0;
    int   windowErr  = 0;

    logic       useModel   = 1'b0;
    logic [7:0] fixedRdata = 8'h00;

    cia_eclk_ctrl_if #(.AW(4), .DW(8)) bus ();

    cia_eclk_ctrl #(
        .AW(4), .DW(8), .E_START(2), .E_STROBE(9)
    ) dut (
        .clk_28 (clk_28),
        .rst    (rst),
        .bus    (bus)
    );

    // CIA register model: reads return the address in the high nibble, its inverse low.
    assign bus.cia_rdata = useModel ? {bus.cia_addr, ~bus.cia_addr} : fixedRdata;

    initial forever #5 clk_28 = ~clk_28;

    initial begin
        logic [9:0] phaseVec;
        bus.clk7_en = 1'b0;
        bus.eclk    = 10'b0000000001;
        forever begin
            @(posedge clk_28);
            #1;
            tick++;
            phaseVec = '0;
            phaseVec[(tick / 4) % 10] = 1'b1;
            bus.clk7_en = ((tick % 4) == 3);
            bus.eclk    = phaseVec;
        end
    end

    // P(2) sits on tick 40m+11, so chip select may only be seen on ticks 40m+12..40m+39.
    always @(negedge clk_28) begin
        if (!rst && bus.cia_sel && ((tick % 40) < 12)) begin
            windowErr++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [3:0] addr,
                                 input logic [7:0] wdata);
        bus.req_we[idx]            = we;
        bus.req_addr[idx*4 +: 4]   = addr;
        bus.req_wdata[idx*8 +: 8]  = wdata;
        bus.req[idx]               = 1'b1;
    endtask

    task automatic waitPhase(input int n);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_28);
            if (bus.clk7_en && bus.eclk[n]) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("phaseSeen", 32'(found), 32'd1);
    endtask

    task automatic waitAck(output logic [1:0] a, output int t);
        logic found;
        found = 1'b0;
        a     = 2'b00;
        t     = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_28);
            if (bus.ack != 2'b00) begin
                a     = bus.ack;
                t     = tick;
                found = 1'b1;
                break;
            end
        end
        checkOutput("ackSeen", 32'(found), 32'd1);
    endtask

    task automatic countAcks(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_28);
            if (bus.ack != 2'b00) n++;
        end
    endtask

    initial begin
        logic [1:0] a;
        int         t;
        int         prevT;
        int         n;
        int         selCycles;
        int         badHold;
        logic [1:0] pending;
        logic [1:0] rndWe;
        logic [3:0] rndAddr [2];
        logic [7:0] rndWdata [2];
        int         raised;
        int         acked;

        bus.req       = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk_28);
        checkOutput("rstAck",    32'(bus.ack),       32'd0);
        checkOutput("rstBusy",   32'(bus.busy),      32'd0);
        checkOutput("rstSel",    32'(bus.cia_sel),   32'd0);
        checkOutput("rstWe",     32'(bus.cia_we),    32'd0);
        checkOutput("rstAddr",   32'(bus.cia_addr),  32'd0);
        checkOutput("rstWdata",  32'(bus.cia_wdata), 32'd0);
        checkOutput("rstRdata",  32'(bus.rdata),     32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_28);

        // Single read: select spans P(2)+1..P(9), ack two cycles after P(9).
        fixedRdata = 8'h5A;
        applyStimulus(0, 1'b0, 4'hD, 8'h00);
        waitPhase(2);
        checkOutput("t2SelAtStart", 32'(bus.cia_sel), 32'd0);
        checkOutput("t2BusyWait",   32'(bus.busy),    32'd1);
        checkOutput("t2AddrLatched", 32'(bus.cia_addr), 32'hD);
        selCycles = 0;
        @(negedge clk_28);
        while (bus.cia_sel && selCycles < 60) begin
            selCycles++;
            @(negedge clk_28);
        end
        checkOutput("t2SelWidth", 32'(selCycles), 32'd28);
        checkOutput("t2AckEarly", 32'(bus.ack),  32'd0);
        checkOutput("t2BusyDone", 32'(bus.busy), 32'd1);
        @(negedge clk_28);
        checkOutput("t2Ack",   32'(bus.ack),   32'd1);
        checkOutput("t2Rdata", 32'(bus.rdata), 32'h5A);
        bus.req = 2'b00;
        @(negedge clk_28);
        checkOutput("t2AckOnce", 32'(bus.ack),  32'd0);
        checkOutput("t2BusyIdle", 32'(bus.busy), 32'd0);
        repeat (5) @(negedge clk_28);

        // Write raised just after P(2) must wait for the following P(2).
        waitPhase(2);
        @(negedge clk_28);
        applyStimulus(0, 1'b1, 4'h1, 8'hC3);
        n = 0;
        do begin
            @(negedge clk_28);
            n++;
        end while (!bus.cia_sel && n < 80);
        checkOutput("t4SelDelay", 32'(n), 32'd40);
        badHold   = 0;
        selCycles = 0;
        while (bus.cia_sel && selCycles < 60) begin
            if (!bus.cia_we || bus.cia_wdata != 8'hC3 || bus.cia_addr != 4'h1) badHold++;
            selCycles++;
            @(negedge clk_28);
        end
        checkOutput("t4HoldBad",  32'(badHold),   32'd0);
        checkOutput("t4SelWidth", 32'(selCycles), 32'd28);
        @(negedge clk_28);
        checkOutput("t4Ack",       32'(bus.ack),   32'd1);
        checkOutput("t4RdataHeld", 32'(bus.rdata), 32'h5A);
        checkOutput("t4WeCleared", 32'(bus.cia_we), 32'd0);
        checkOutput("t4WdataHeld", 32'(bus.cia_wdata), 32'hC3);
        bus.req = 2'b00;
        repeat (5) @(negedge clk_28);

        // Requester withdraws mid-access; the access still finishes with one ack.
        fixedRdata = 8'h3C;
        applyStimulus(0, 1'b0, 4'h7, 8'h00);
        waitPhase(2);
        repeat (10) @(negedge clk_28);
        checkOutput("t5SelMid", 32'(bus.cia_sel), 32'd1);
        bus.req = 2'b00;
        waitAck(a, t);
        checkOutput("t5Ack",   32'(a),         32'd1);
        checkOutput("t5Rdata", 32'(bus.rdata), 32'h3C);
        countAcks(60, n);
        checkOutput("t5NoExtraAck", 32'(n), 32'd0);

        // Asynchronous reset during ACTIVE aborts with no ack.
        applyStimulus(0, 1'b0, 4'h2, 8'h00);
        waitPhase(2);
        repeat (5) @(negedge clk_28);
        checkOutput("t1SelBefore", 32'(bus.cia_sel), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t1Sel",  32'(bus.cia_sel), 32'd0);
        checkOutput("t1Ack",  32'(bus.ack),     32'd0);
        checkOutput("t1Busy", 32'(bus.busy),    32'd0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk_28);
        rst = 1'b0;
        countAcks(60, n);
        checkOutput("t1NoAck", 32'(n), 32'd0);

        // Simultaneous requests from reset: requester 0 first, then strict alternation.
        applyStimulus(0, 1'b0, 4'h3, 8'h00);
        applyStimulus(1, 1'b0, 4'h4, 8'h00);
        prevT = 0;
        for (int k = 0; k < 4; k++) begin
            waitAck(a, t);
            checkOutput($sformatf("t3AckOrder%0d", k), 32'(a), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) checkOutput($sformatf("t3Spacing%0d", k), 32'(t - prevT), 32'd40);
            prevT   = t;
            bus.req = bus.req & ~a;
            if (k == 3) begin
                bus.req = 2'b00;
            end else begin
                @(negedge clk_28);
                bus.req = bus.req | a;
            end
        end
        repeat (50) @(negedge clk_28);

        // Random traffic with a scoreboard over 200 E periods.
        useModel = 1'b1;
        pending  = 2'b00;
        rndWe    = 2'b00;
        raised   = 0;
        acked    = 0;
        for (int c = 0; c < 8200; c++) begin
            @(negedge clk_28);
            if (bus.ack != 2'b00) begin
                checkOutput("rndAckOneHot", 32'($onehot(bus.ack)), 32'd1);
                for (int i = 0; i < 2; i++) begin
                    if (bus.ack[i]) begin
                        checkOutput($sformatf("rndPending%0d", i), 32'(pending[i]), 32'd1);
                        checkOutput($sformatf("rndAddr%0d", i), 32'(bus.cia_addr), 32'(rndAddr[i]));
                        if (rndWe[i])
                            checkOutput($sformatf("rndWdata%0d", i), 32'(bus.cia_wdata), 32'(rndWdata[i]));
                        else
                            checkOutput($sformatf("rndRdata%0d", i), 32'(bus.rdata),
                                        32'({rndAddr[i], ~rndAddr[i]}));
                        pending[i] = 1'b0;
                        bus.req[i] = 1'b0;
                        acked++;
                    end
                end
            end else if (c < 8000) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pending[i] && $urandom_range(0, 7) == 0) begin
                        rndWe[i]    = 1'($urandom_range(0, 1));
                        rndAddr[i]  = 4'($urandom_range(0, 15));
                        rndWdata[i] = 8'($urandom_range(0, 255));
                        applyStimulus(i, rndWe[i], rndAddr[i], rndWdata[i]);
                        pending[i] = 1'b1;
                        raised++;
                    end
                end
            end
        end
        checkOutput("rndDrained",  32'(pending), 32'd0);
        checkOutput("rndAckCount", 32'(acked),   32'(raised));
        checkOutput("selWindow",   32'(windowErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
